pipeline_hold_ctrl: RTL and testbench
=====================================

PIPELINE_HOLD_CTRL -- requirements
Module: pipeline_hold_ctrl

Interface
REQ-001 Parameter: MEM_LAT, 2, total hold cycles inserted per memory access, legal 1..15.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: id_ra, id_rb  input  3 each  source register numbers of the instruction in ID.
REQ-005 Port: id_use_ra, id_use_rb  input  1 each  ID instruction actually reads ra / rb.
REQ-006 Port: ex_load  input  1  EX instruction is a load; ex_rd input 3 its destination register.
REQ-007 Port: mem_req  input  1  instruction in MEM requests a data-memory access; held until mem_ack.
REQ-008 Port: branch_taken  input  1  branch resolved taken in EX this cycle.
REQ-009 Port: halt  input  1  HLT instruction in EX; resume  input  1  restart from halt.
REQ-010 Port: preserve_pc, preserve_ifid, preserve_idex, preserve_exmem  output  1 each  1 = register keeps current value (drives preserve muxes), 0 = loads next.
REQ-011 Port: bubble_idex  output  1  load NOP into ID/EX; flush_ifid  output  1  load NOP into IF/ID.
REQ-012 Port: mem_ack  output  1  memory access completes this cycle; state  output  2  FSM state; stall_cnt  output  16  stalled-cycle counter.

Function
REQ-013 FSM states SHALL be RUN=0, MEMWAIT=1, HALT=2; encoding 3 unreachable and SHALL recover to RUN next cycle.
REQ-014 hazard SHALL equal ex_load & ((id_use_ra & id_ra==ex_rd) | (id_use_rb & id_rb==ex_rd)).
REQ-015 All hold/flush outputs SHALL be combinational from state, internal ack flag and inputs; state, counter, mem_ack, stall_cnt registered.
REQ-016 RUN priority SHALL be: memory stall > halt > branch > hazard > none.
REQ-017 RUN, mem_req=1, ack flag=0: all four preserve outputs=1; if MEM_LAT>1 next state MEMWAIT with wait counter=MEM_LAT-1, else remain RUN with ack flag set.
REQ-018 MEMWAIT: all four preserve=1; counter decrements each cycle; on counter reaching 1 (before decrement) next state RUN and ack flag set.
REQ-019 mem_ack SHALL equal the ack flag; while ack flag=1 mem_req SHALL be ignored for one RUN cycle and flag cleared at its end; total hold cycles per access exactly MEM_LAT.
REQ-020 RUN, halt=1, no memory stall: all preserve=1, next state HALT.
REQ-021 HALT: all preserve=1; resume=1 SHALL move to RUN next cycle; all other inputs ignored.
REQ-022 RUN, branch_taken=1, no higher event: flush_ifid=1, bubble_idex=1, all preserve=0; hazard ignored.
REQ-023 RUN, hazard=1, no higher event: preserve_pc=1, preserve_ifid=1, bubble_idex=1, preserve_idex=0, preserve_exmem=0; stall lasts exactly one cycle since the bubble clears ex_load.
REQ-024 bubble_idex and flush_ifid SHALL be 0 whenever any preserve output from a memory stall or HALT is 1.
REQ-025 stall_cnt SHALL increment by 1 every cycle preserve_pc=1 outside HALT, saturating at 0xFFFF.

Reset
REQ-026 rst_n=0 SHALL immediately force state=RUN, wait counter=0, ack flag=0, mem_ack=0, stall_cnt=0, and all preserve, bubble and flush outputs 0, independent of clk.
REQ-027 Reset asserted mid-MEMWAIT or in HALT SHALL abandon the operation; first cycle after release behaves as RUN with no pending access.

Verification
REQ-028 MEM_LAT=3, mem_req held from cycle 0 -> preserve_* =1 cycles 0-2, mem_ack=1 cycle 3 with preserve_*=0, stall_cnt=3.
REQ-029 ex_load=1, ex_rd=5, id_ra=5, id_use_ra=1 one cycle -> preserve_pc=preserve_ifid=bubble_idex=1, preserve_exmem=0 that cycle only, stall_cnt=1.
REQ-030 branch_taken=1 with hazard=1 same cycle -> flush_ifid=bubble_idex=1, all preserve=0, stall_cnt unchanged.
REQ-031 mem_req=1 and branch_taken=1 together, MEM_LAT=2 -> 2 hold cycles, no flush; flush_ifid=1 in cycle after mem_ack if branch_taken still 1.
REQ-032 halt=1 -> state=2, all preserve=1 for 10 cycles, stall_cnt unchanged; resume=1 -> state=0 next cycle.
REQ-033 rst_n pulsed low in 2nd MEMWAIT cycle (MEM_LAT=4) -> outputs 0 immediately, state=0, stall_cnt=0, no mem_ack after release.

Source files
------------

// File: rtl/pipeline_hold_ctrl.sv
// Pipeline hold/flush controller for a 5-stage in-order pipeline.
// The controller arbitrates four sources of pipeline disturbance:
//   - memory-access stalls (MEM_LAT hold cycles),
//   - HLT/resume,
//   - taken branches (flush IF/ID and bubble ID/EX),
//   - load-use hazards (one-cycle stall with a bubble).
// It drives the preserve muxes of PC/IF-ID/ID-EX/EX-MEM and keeps a
// saturating count of stalled cycles.
module pipeline_hold_ctrl #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  id_ra,
  input  logic [2:0]  id_rb,
  input  logic        id_use_ra,
  input  logic        id_use_rb,
  input  logic        ex_load,
  input  logic [2:0]  ex_rd,
  input  logic        mem_req,
  input  logic        branch_taken,
  input  logic        halt,
  input  logic        resume,
  output logic        preserve_pc,
  output logic        preserve_ifid,
  output logic        preserve_idex,
  output logic        preserve_exmem,
  output logic        bubble_idex,
  output logic        flush_ifid,
  output logic        mem_ack,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALT    = 2'd2,
    BAD     = 2'd3
  } state_t;

  state_t      st;
  logic [3:0]  wcnt;
  logic        ack_q;
  logic [15:0] cnt_q;
  logic        hazard;
  logic        mem_stall;

  assign state     = st;
  assign mem_ack   = ack_q;
  assign stall_cnt = cnt_q;

  // Load-use hazard: EX load writes a register the ID instruction reads.
  assign hazard = ex_load & ((id_use_ra & (id_ra == ex_rd)) |
                             (id_use_rb & (id_rb == ex_rd)));

  // A request is ignored for the one RUN cycle in which its ack is presented.
  assign mem_stall = mem_req & ~ack_q;

  // Hold/flush decode; everything forced low while reset is asserted.
  always_comb begin
    preserve_pc    = 1'b0;
    preserve_ifid  = 1'b0;
    preserve_idex  = 1'b0;
    preserve_exmem = 1'b0;
    bubble_idex    = 1'b0;
    flush_ifid     = 1'b0;
    if (rst_n) begin
      case (st)
        RUN: begin
          if (mem_stall || halt) begin
            preserve_pc    = 1'b1;
            preserve_ifid  = 1'b1;
            preserve_idex  = 1'b1;
            preserve_exmem = 1'b1;
          end else if (branch_taken) begin
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
          end else if (hazard) begin
            preserve_pc   = 1'b1;
            preserve_ifid = 1'b1;
            bubble_idex   = 1'b1;
          end
        end
        MEMWAIT, HALT: begin
          preserve_pc    = 1'b1;
          preserve_ifid  = 1'b1;
          preserve_idex  = 1'b1;
          preserve_exmem = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // FSM, memory wait counter, ack flag and saturating stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= RUN;
      wcnt  <= 4'd0;
      ack_q <= 1'b0;
      cnt_q <= 16'd0;
    end else begin
      case (st)
        RUN: begin
          ack_q <= 1'b0;
          if (mem_stall) begin
            if (MEM_LAT > 1) begin
              st   <= MEMWAIT;
              wcnt <= 4'(MEM_LAT - 1);
            end else begin
              ack_q <= 1'b1;
            end
          end else if (halt) begin
            st <= HALT;
          end
        end
        MEMWAIT: begin
          if (wcnt <= 4'd1) begin
            st    <= RUN;
            wcnt  <= 4'd0;
            ack_q <= 1'b1;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        HALT: begin
          if (resume) st <= RUN;
        end
        default: begin
          st    <= RUN;
          wcnt  <= 4'd0;
          ack_q <= 1'b0;
        end
      endcase
      if (preserve_pc && st != HALT && cnt_q != 16'hFFFF)
        cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hold_ctrl.sv
// Randomised + directed bench for pipeline_hold_ctrl. The driver computes
// the expected per-cycle outputs from a behavioural model and queues them;
// the monitor pops and compares on each falling edge.
module tb_pipeline_hold_ctrl;
  localparam int MEM_LAT = 3;

  typedef struct packed {
    logic [2:0] ra, rb;
    logic       use_ra, use_rb, ex_load;
    logic [2:0] ex_rd;
    logic       mem_req, branch, halt, resume;
  } in_t;

  typedef struct packed {
    logic [1:0]  state;
    logic        ack;
    logic [15:0] cnt;
    logic        pc, ifid, idex, exmem, bub, flush;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [2:0] id_ra = '0, id_rb = '0, ex_rd = '0;
  logic id_use_ra = 0, id_use_rb = 0, ex_load = 0, mem_req = 0;
  logic branch_taken = 0, halt = 0, resume = 0;
  logic preserve_pc, preserve_ifid, preserve_idex, preserve_exmem;
  logic bubble_idex, flush_ifid, mem_ack;
  logic [1:0] state;
  logic [15:0] stall_cnt;

  pipeline_hold_ctrl #(.MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_ra(id_ra), .id_rb(id_rb),
    .id_use_ra(id_use_ra), .id_use_rb(id_use_rb), .ex_load(ex_load),
    .ex_rd(ex_rd), .mem_req(mem_req), .branch_taken(branch_taken),
    .halt(halt), .resume(resume), .preserve_pc(preserve_pc),
    .preserve_ifid(preserve_ifid), .preserve_idex(preserve_idex),
    .preserve_exmem(preserve_exmem), .bubble_idex(bubble_idex),
    .flush_ifid(flush_ifid), .mem_ack(mem_ack), .state(state),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: how far through the current access we are, whether
  // an ack is due, whether halted, and how many stalled cycles so far.
  int   holds_done = 0;
  bit   ack_pend = 0;
  bit   halted = 0;
  int   stalls = 0;
  exp_t expq[$];
  bit   done = 0;
  bit   req_hold = 0;

  function automatic void model_reset();
    holds_done = 0; ack_pend = 0; halted = 0; stalls = 0;
  endfunction

  function automatic void bump();
    if (stalls < 65535) stalls++;
  endfunction

  function automatic exp_t model(in_t i);
    exp_t e;
    bit haz;
    e = '0;
    haz = i.ex_load && ((i.use_ra && i.ra == i.ex_rd) || (i.use_rb && i.rb == i.ex_rd));
    e.state = halted ? 2'd2 : (holds_done > 0 ? 2'd1 : 2'd0);
    e.ack   = ack_pend;
    e.cnt   = 16'(stalls);
    if (halted) begin
      {e.pc, e.ifid, e.idex, e.exmem} = 4'hF;
      if (i.resume) halted = 0;
    end else if (holds_done > 0 || (i.mem_req && !ack_pend)) begin
      {e.pc, e.ifid, e.idex, e.exmem} = 4'hF;
      bump();
      holds_done++;
      if (holds_done == MEM_LAT) begin
        holds_done = 0;
        ack_pend = 1;
      end
    end else begin
      ack_pend = 0;
      if (i.halt) begin
        {e.pc, e.ifid, e.idex, e.exmem} = 4'hF;
        bump();
        halted = 1;
      end else if (i.branch) begin
        e.flush = 1; e.bub = 1;
      end else if (haz) begin
        e.pc = 1; e.ifid = 1; e.bub = 1;
        bump();
      end
    end
    return e;
  endfunction

  task automatic step(input in_t i);
    @(posedge clk); #2;
    rst_n = 1'b1;
    {id_ra, id_rb, id_use_ra, id_use_rb, ex_load, ex_rd,
     mem_req, branch_taken, halt, resume} = i;
    expq.push_back(model(i));
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    {id_ra, id_rb, id_use_ra, id_use_rb, ex_load, ex_rd,
     mem_req, branch_taken, halt, resume} = '0;
    model_reset();
    req_hold = 0;
    expq.push_back('0);
  endtask

  function automatic in_t idle();
    return '0;
  endfunction

  function automatic in_t rnd();
    in_t i;
    i.ra      = 3'($urandom_range(0, 3));
    i.rb      = 3'($urandom_range(0, 3));
    i.ex_rd   = 3'($urandom_range(0, 3));
    i.use_ra  = 1'($urandom_range(0, 1));
    i.use_rb  = 1'($urandom_range(0, 1));
    i.ex_load = 1'($urandom_range(0, 1));
    i.mem_req = req_hold ? 1'b1 : 1'($urandom_range(0, 3) == 0);
    i.branch  = 1'($urandom_range(0, 5) == 0);
    i.halt    = 1'($urandom_range(0, 19) == 0);
    i.resume  = 1'($urandom_range(0, 3) == 0);
    return i;
  endfunction

  // Driver: directed scenarios, then constrained-random traffic.
  initial begin
    in_t i;
    do_reset();
    // Memory access held from cycle 0; ack cycle still has mem_req high.
    i = idle(); i.mem_req = 1;
    repeat (MEM_LAT + 1) step(i);
    step(idle());
    // Load-use hazard on ra for one cycle, then bubble clears ex_load.
    i = idle(); i.ex_load = 1; i.ex_rd = 3'd5; i.ra = 3'd5; i.use_ra = 1;
    step(i);
    step(idle());
    // Hazard on rb only.
    i = idle(); i.ex_load = 1; i.ex_rd = 3'd2; i.rb = 3'd2; i.use_rb = 1; i.ra = 3'd2;
    step(i);
    // Same registers but not used: no hazard.
    i.use_rb = 0;
    step(i);
    // Branch together with hazard: branch wins.
    i = idle(); i.ex_load = 1; i.ex_rd = 3'd1; i.ra = 3'd1; i.use_ra = 1; i.branch = 1;
    step(i);
    // Memory request with branch: holds first, flush after ack.
    i = idle(); i.mem_req = 1; i.branch = 1;
    repeat (MEM_LAT + 1) step(i);
    i.mem_req = 0;
    step(i);
    // Halt with 10 ignored cycles, then resume.
    i = idle(); i.halt = 1;
    step(i);
    i = idle(); i.mem_req = 1; i.branch = 1; i.halt = 1;
    repeat (10) step(i);
    i = idle(); i.resume = 1;
    step(i);
    step(idle());
    // Reset asserted in the second MEMWAIT cycle abandons the access.
    i = idle(); i.mem_req = 1;
    repeat (2) step(i);
    do_reset();
    repeat (4) step(idle());
    // Random traffic; mem_req held until its ack is presented.
    for (int n = 0; n < 800; n++) begin
      exp_t e;
      if (n == 400) do_reset();
      i = rnd();
      step(i);
      e = expq[$];
      if (e.ack) req_hold = 0;
      else if (i.mem_req) req_hold = 1;
    end
    step(idle());
    done = 1;
  end

  // Monitor / scoreboard: owns the counters and ends the run.
  initial begin
    int checks = 0, failures = 0, cyc = 0;
    exp_t e, a;
    forever begin
      @(negedge clk);
      cyc++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a = '{state: state, ack: mem_ack, cnt: stall_cnt,
              pc: preserve_pc, ifid: preserve_ifid, idex: preserve_idex,
              exmem: preserve_exmem, bub: bubble_idex, flush: flush_ifid};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL outputs cycle=%0d got st=%0d ack=%b cnt=%0d pres=%b%b%b%b bub=%b fl=%b want st=%0d ack=%b cnt=%0d pres=%b%b%b%b bub=%b fl=%b",
                   cyc, a.state, a.ack, a.cnt, a.pc, a.ifid, a.idex, a.exmem, a.bub, a.flush,
                   e.state, e.ack, e.cnt, e.pc, e.ifid, e.idex, e.exmem, e.bub, e.flush);
        end
      end else if (done) begin
        break;
      end
      if (cyc > 5000) begin
        checks++;
        failures++;
        $display("FAIL timeout got cycles=%0d want <=5000", cyc);
        break;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
